// File: rtl/req_rsp_responder.sv
// rtl/req_rsp_responder.sv - tagged request/response responder with fixed latency and bounded outstanding
// Optional assertions compiled when REQ_RSP_RESPONDER_ASSERT_EN is defined.
module req_rsp_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [TAG_W-1:0] a_tag,
  output logic             a_ready,
  output logic             a_drop,
  output logic             b,
  output logic [TAG_W-1:0] b_tag,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] outstanding
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             acc;
  logic             pop;
  logic             push;
  logic [TAG_W-1:0] push_tag;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  assign a_ready = outstanding < CNT_W'(DEPTH);
  assign acc     = a && a_ready;
  assign b       = fifo_cnt != '0;
  assign pop     = b && rsp_ready;
  // Drive zero when empty so nothing stale is ever visible on b_tag.
  assign b_tag   = b ? mem[rd_ptr] : '0;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    if (LATENCY == 1) begin : g_direct
      assign push     = acc;
      assign push_tag = a_tag;
    end else begin : g_dly
      localparam int N = LATENCY - 1;
      logic [N-1:0]     v;
      logic [TAG_W-1:0] t [N];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v <= '0;
        end else begin
          v[0] <= acc;
          for (int i = 1; i < N; i++) v[i] <= v[i-1];
        end
      end

      // Tag stages need no reset: they are only observed alongside a valid bit.
      always_ff @(posedge clk) begin
        t[0] <= a_tag;
        for (int i = 1; i < N; i++) t[i] <= t[i-1];
      end

      assign push     = v[N-1];
      assign push_tag = t[N-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      a_drop      <= 1'b0;
    end else begin
      a_drop <= a && !a_ready;
      if (push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (acc && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !acc) outstanding <= outstanding - 1'b1;
    end
  end

`ifdef REQ_RSP_RESPONDER_ASSERT_EN
  a_hold_p: assert property (@(posedge clk) disable iff (!rst_n)
    b && !rsp_ready |=> b && $stable(b_tag));
  a_full_p: assert property (@(posedge clk) disable iff (!rst_n)
    !a_ready |-> outstanding == CNT_W'(DEPTH));
  a_lat_p: assert property (@(posedge clk) disable iff (!rst_n)
    a && a_ready && outstanding == '0 |-> ##LATENCY b);
  a_bound_p: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= CNT_W'(DEPTH));
`else
`endif

endmodule

// File: tb/tb_req_rsp_responder.sv
// tb/tb_req_rsp_responder.sv - self-checking bench for req_rsp_responder against a queue model
module tb_req_rsp_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic [3:0] a_tag;
  logic       rsp_ready;

  logic       a_ready0, a_drop0, b0;
  logic [3:0] b_tag0;
  logic [2:0] out0;
  logic       a_ready1, a_drop1, b1;
  logic [3:0] b_tag1;
  logic [1:0] out1;

  always #5 clk = ~clk;

  req_rsp_responder #(.LATENCY(2), .DEPTH(4), .TAG_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .a_tag(a_tag), .a_ready(a_ready0),
    .a_drop(a_drop0), .b(b0), .b_tag(b_tag0), .rsp_ready(rsp_ready),
    .outstanding(out0)
  );

  req_rsp_responder #(.LATENCY(1), .DEPTH(3), .TAG_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .a_tag(a_tag), .a_ready(a_ready1),
    .a_drop(a_drop1), .b(b1), .b_tag(b_tag1), .rsp_ready(rsp_ready),
    .outstanding(out1)
  );

  bit         sel;
  logic       o_b, o_ready, o_drop;
  logic [3:0] o_tag;
  int         o_out;

  always_comb begin
    o_b     = sel ? b1 : b0;
    o_ready = sel ? a_ready1 : a_ready0;
    o_drop  = sel ? a_drop1 : a_drop0;
    o_tag   = sel ? b_tag1 : b_tag0;
    o_out   = sel ? int'(out1) : int'(out0);
  end

  int nerr = 0;
  int nchk = 0;

  // Reference model: accepted requests in order, each with the cycle its response is due.
  int         q_tag[$];
  int         q_due[$];
  int         cyc = 0;
  int         lat = 2;
  int         dep = 4;
  logic       drop_next = 1'b0;
  logic       exp_b, exp_ready, exp_drop;
  logic [3:0] exp_tag;
  int         exp_out;

  task automatic step();
    bit   m_ready, m_b, m_acc, m_pop, m_a, m_rst;
    logic [3:0] m_tag;
    m_ready = q_tag.size() < dep;
    m_b     = (q_tag.size() > 0) ? (q_due[0] <= cyc) : 1'b0;
    m_a     = a;
    m_tag   = a_tag;
    m_rst   = !rst_n;
    m_acc   = m_a && m_ready;
    m_pop   = m_b && rsp_ready;
    @(posedge clk);
    cyc++;
    if (m_rst) begin
      q_tag.delete();
      q_due.delete();
      drop_next = 1'b0;
    end else begin
      drop_next = m_a && !m_ready;
      if (m_pop) begin
        void'(q_tag.pop_front());
        void'(q_due.pop_front());
      end
      if (m_acc) begin
        q_tag.push_back(int'(m_tag));
        q_due.push_back(cyc - 1 + lat);
      end
    end
    #1;
    exp_b     = (q_tag.size() > 0) ? (q_due[0] <= cyc) : 1'b0;
    exp_tag   = exp_b ? 4'(q_tag[0]) : 4'h0;
    exp_out   = q_tag.size();
    exp_ready = q_tag.size() < dep;
    exp_drop  = drop_next;
  endtask

  task automatic idle();
    a = 1'b0;
    a_tag = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0; idle();
    step(); step();
    rst_n = 1'b1;
    step();
    nchk++; if (o_b !== 1'b0) begin nerr++; $display("FAIL reset_b got=%b exp=0", o_b); end
    nchk++; if (o_tag !== 4'h0) begin nerr++; $display("FAIL reset_tag got=%h exp=0", o_tag); end
    nchk++; if (o_out !== 0) begin nerr++; $display("FAIL reset_out got=%0d exp=0", o_out); end
    nchk++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    nchk++; if (o_drop !== 1'b0) begin nerr++; $display("FAIL reset_drop got=%b exp=0", o_drop); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    a = 1'b1; a_tag = 4'h5;
    step();
    idle();
    for (int k = 1; k <= 3; k++) begin
      nchk++; if (o_b !== (k == 2)) begin nerr++; $display("FAIL single_b k=%0d got=%b exp=%b", k, o_b, k == 2); end
      if (k == 2) begin
        nchk++; if (o_tag !== 4'h5) begin nerr++; $display("FAIL single_tag got=%h exp=5", o_tag); end
      end
      nchk++; if (o_out !== ((k <= 2) ? 1 : 0)) begin nerr++; $display("FAIL single_out k=%0d got=%0d exp=%0d", k, o_out, (k <= 2) ? 1 : 0); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = (k < 4); a_tag = 4'(k + 1);
      nchk++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, o_ready); end
      nchk++; if (o_b !== (k >= 2 && k <= 5)) begin nerr++; $display("FAIL b2b_b k=%0d got=%b exp=%b", k, o_b, k >= 2 && k <= 5); end
      if (k >= 2 && k <= 5) begin
        nchk++; if (o_tag !== 4'(k - 1)) begin nerr++; $display("FAIL b2b_tag k=%0d got=%h exp=%h", k, o_tag, 4'(k - 1)); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    int e_out;
    logic [3:0] e_tag;
    for (int k = 0; k <= 10; k++) begin
      a = (k <= 4); a_tag = 4'(k + 1);
      rsp_ready = (k >= 6);
      nchk++; if (o_ready !== (k != 4 && k != 5 && k != 6)) begin nerr++; $display("FAIL bp_ready k=%0d got=%b", k, o_ready); end
      nchk++; if (o_drop !== (k == 5)) begin nerr++; $display("FAIL bp_drop k=%0d got=%b exp=%b", k, o_drop, k == 5); end
      nchk++; if (o_b !== (k >= 2 && k <= 9)) begin nerr++; $display("FAIL bp_b k=%0d got=%b exp=%b", k, o_b, k >= 2 && k <= 9); end
      if (k >= 2 && k <= 9) begin
        e_tag = (k <= 6) ? 4'h1 : 4'(k - 5);
        nchk++; if (o_tag !== e_tag) begin nerr++; $display("FAIL bp_tag k=%0d got=%h exp=%h", k, o_tag, e_tag); end
      end
      e_out = (k <= 6) ? ((k < 4) ? k : 4) : 10 - k;
      nchk++; if (o_out !== e_out) begin nerr++; $display("FAIL bp_out k=%0d got=%0d exp=%0d", k, o_out, e_out); end
      step();
    end
    idle();
  endtask

  task automatic test_full_consume();
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = (k < 4); a_tag = 4'(k + 6);
      step();
    end
    a = 1'b1; a_tag = 4'hA; rsp_ready = 1'b1;
    nchk++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got=%b exp=0", o_ready); end
    nchk++; if (o_out !== 4) begin nerr++; $display("FAIL full_out got=%0d exp=4", o_out); end
    nchk++; if (o_tag !== 4'h6) begin nerr++; $display("FAIL full_tag got=%h exp=6", o_tag); end
    step();
    rsp_ready = 1'b0;
    nchk++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL full_ready2 got=%b exp=1", o_ready); end
    nchk++; if (o_drop !== 1'b1) begin nerr++; $display("FAIL full_drop got=%b exp=1", o_drop); end
    nchk++; if (o_out !== 3) begin nerr++; $display("FAIL full_out2 got=%0d exp=3", o_out); end
    step();
    idle(); rsp_ready = 1'b1;
    nchk++; if (o_out !== 4) begin nerr++; $display("FAIL full_out3 got=%0d exp=4", o_out); end
    for (int k = 0; k < 4; k++) begin
      nchk++; if (o_b !== 1'b1 || o_tag !== 4'(k + 7)) begin nerr++; $display("FAIL full_drain k=%0d got=%b/%h exp=1/%h", k, o_b, o_tag, 4'(k + 7)); end
      step();
    end
    nchk++; if (o_b !== 1'b0) begin nerr++; $display("FAIL full_empty got=%b exp=0", o_b); end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 1'b1; a_tag = 4'(k + 11);
      step();
    end
    idle(); rst_n = 1'b0;
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    nchk++; if (o_b !== 1'b0) begin nerr++; $display("FAIL mid_b got=%b exp=0", o_b); end
    nchk++; if (o_out !== 0) begin nerr++; $display("FAIL mid_out got=%0d exp=0", o_out); end
    nchk++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready got=%b exp=1", o_ready); end
    for (int k = 0; k < 6; k++) begin
      step();
      nchk++; if (o_b !== 1'b0) begin nerr++; $display("FAIL mid_stale k=%0d got=%b/%h exp=0", k, o_b, o_tag); end
    end
  endtask

  task automatic test_random(input bit s, input int n);
    int pops;
    sel = s;
    lat = s ? 1 : 2;
    dep = s ? 3 : 4;
    rst_n = 1'b0; idle(); rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    pops = 0;
    for (int k = 0; k < n; k++) begin
      a         = ($urandom_range(0, 3) != 0);
      a_tag     = 4'($urandom_range(0, 15));
      rsp_ready = (k < n / 2) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      nchk++; if (o_b !== exp_b) begin nerr++; $display("FAIL rnd%0d_b k=%0d got=%b exp=%b", s, k, o_b, exp_b); end
      if (exp_b) begin
        nchk++; if (o_tag !== exp_tag) begin nerr++; $display("FAIL rnd%0d_tag k=%0d got=%h exp=%h", s, k, o_tag, exp_tag); end
        if (rsp_ready) pops++;
      end
      nchk++; if (o_out !== exp_out) begin nerr++; $display("FAIL rnd%0d_out k=%0d got=%0d exp=%0d", s, k, o_out, exp_out); end
      nchk++; if (o_ready !== exp_ready) begin nerr++; $display("FAIL rnd%0d_ready k=%0d got=%b exp=%b", s, k, o_ready, exp_ready); end
      nchk++; if (o_drop !== exp_drop) begin nerr++; $display("FAIL rnd%0d_drop k=%0d got=%b exp=%b", s, k, o_drop, exp_drop); end
      step();
    end
    nchk++; if (pops < n / 20) begin nerr++; $display("FAIL rnd%0d_activity got=%0d exp>=%0d", s, pops, n / 20); end
    idle();
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_consume();
    test_reset_midflight();
    test_random(1'b0, 2000);
    test_random(1'b1, 2000);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/req_rsp_responder.md
Name: req_rsp_responder

Overview:
- Responder end of the single-bit request/response handshake (`a` request, `b` response) that the team's `a |-> b` properties check.
- Accepts tagged request pulses on `a` and returns each tag on `b` exactly LATENCY cycles later, in request order.
- Queues responses when the consumer back-pressures and bounds total outstanding requests to DEPTH.
- Sits as the target-side model/IP opposite any initiator driving `a`; used both in RTL and as a bench responder for assertion tests.

Parameters:
- LATENCY, 2, cycles from accepted request to response; legal range 1..16.
- DEPTH, 4, max outstanding requests (delay line + response queue); legal range 1..16.
- TAG_W, 4, request/response tag width; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  1  request valid; one request per cycle where high
- a_tag  input  TAG_W  tag sampled with `a`
- a_ready  output  1  high when outstanding < DEPTH
- a_drop  output  1  one-cycle pulse, cycle after `a` high while `a_ready` low
- b  output  1  response valid
- b_tag  output  TAG_W  tag of head response
- rsp_ready  input  1  consumer accepts response when `b && rsp_ready`
- outstanding  output  $clog2(DEPTH+1)  requests accepted but not yet consumed

Behaviour:
- Reset: sampled at posedge while rst_n low. Clears the delay line and response queue. Forces a_ready=1, a_drop=0, b=0, b_tag=0, outstanding=0. Reset mid-operation discards all in-flight tags; none reappear after reset.
- Accept: request accepted when `a && a_ready` at a posedge. `a && !a_ready` is discarded and pulses a_drop in the next cycle. Outstanding is unchanged by a drop.
- Pipeline: accepted tag traverses LATENCY-1 delay registers (valid bit per stage), then writes into a DEPTH-entry FIFO.
  - `b` = FIFO not empty; `b_tag` = FIFO head.
  - Request in cycle t with empty queue gives b=1 and b_tag=tag in cycle t+LATENCY.
  - LATENCY=1: zero delay registers; tag written to the FIFO directly.
- Ordering: responses leave strictly in acceptance order; no reordering or merging.
- Back-pressure:
  - While `b && !rsp_ready`, b and b_tag hold stable.
  - The delay line keeps advancing; arriving tags enqueue behind the head.
  - FIFO overflow is impossible by construction, because outstanding ≤ DEPTH gates acceptance.
- Outstanding counter:
  - +1 on accept, −1 on `b && rsp_ready`.
  - Both in the same cycle: unchanged.
  - Saturation is never reached (bounded by DEPTH).
- a_ready is combinational from outstanding (a_ready = outstanding < DEPTH). A consume in cycle t does not free a slot for an accept in the same cycle t; it frees one from t+1.
- Simultaneous enqueue and dequeue on the FIFO in one cycle is legal in every state, including full-minus-one and single-entry. A single-entry FIFO that is dequeued and enqueued in the same cycle keeps b=1 with the new tag next cycle.
- Pointer wrap-around: FIFO pointers are modulo DEPTH; DEPTH need not be a power of two.

Optional Feature:
- Macro: REQ_RSP_RESPONDER_ASSERT_EN.
- Defined: module-level concurrent assertions, clocked on posedge clk and disabled during !rst_n. None are placed inside always/initial/forever blocks.
  - (1) `b && !rsp_ready |=> b && $stable(b_tag)`
  - (2) `!a_ready |-> outstanding == DEPTH`
  - (3) `a && a_ready && outstanding == 0 |-> ##LATENCY b`
  - (4) outstanding never exceeds DEPTH
- Undefined: no assertion code compiled; RTL behaviour identical.

Test Plan:
- Reset then single request a=1, a_tag=4'h5 in cycle 10, rsp_ready=1 → b=1, b_tag=5 in cycle 12 only; outstanding 1 in cycles 11–12, 0 in cycle 13.
- Back-to-back tags 1,2,3,4 in cycles 10–13, rsp_ready=1 → b high cycles 12–15 with tags 1,2,3,4; a_ready stays 1.
- rsp_ready=0 from cycle 0, tags 1..4 accepted, 5th request in cycle 14 → a_ready=0 in cycle 14, a_drop=1 in cycle 15; b_tag holds 1 while stalled; raising rsp_ready drains tags 1,2,3,4 on consecutive cycles.
- Full queue, same cycle consume (rsp_ready=1) and request (a=1) → new request dropped (a_ready=0 that cycle), accepted next cycle; order preserved.
- rst_n=0 for one cycle with 3 tags in flight → next cycle b=0, outstanding=0, a_ready=1; no stale tag ever appears on b.
- Build with REQ_RSP_RESPONDER_ASSERT_EN, LATENCY=1, DEPTH=3, random a/rsp_ready for 2000 cycles → zero assertion failures; scoreboard matches tag order.
